// File: rtl/ctrl_em_seq.sv
// ctrl_em_seq: execute-to-memory control register with a multi-cycle FPU sequencer (falling-edge clocked).
// Define CTRL_EM_STALL_CNT_EN to add the StallCnt output (count of stalled cycles, wraps at 2^32).
module ctrl_em_seq #(
    parameter int unsigned MUL_LAT  = 3,
    parameter int unsigned DIV_LAT  = 12,
    parameter int unsigned SQRT_LAT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        RegWriteE,
    input  logic        FRegWriteE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic [1:0]  JmpE,
    input  logic        FPUEnableE,
    input  logic [2:0]  Fun3E,
    input  logic [6:0]  Fun7E,
    input  logic [4:0]  RdE,
    output logic        RegWriteM,
    output logic        FRegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [1:0]  JmpM,
    output logic [2:0]  Fun3M,
    output logic [4:0]  RdM,
    output logic        StallE,
    output logic        FpuBusy
`ifdef CTRL_EM_STALL_CNT_EN
    ,
    output logic [31:0] StallCnt
`endif
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e     state_q;
    logic [5:0] cnt_q;
    logic       busy_q;
    logic       regw_q, fregw_q, memw_q, rsrc_q;
    logic [1:0] jmp_q;
    logic [2:0] fun3_q;
    logic [4:0] rd_q;

    logic [5:0] lat;
    logic       mc;
    logic       capture;

    always_comb begin
        case (Fun7E)
            7'b0001000: lat = 6'(MUL_LAT);
            7'b0001100: lat = 6'(DIV_LAT);
            7'b0101100: lat = 6'(SQRT_LAT);
            default:    lat = 6'd1;
        endcase
        mc = FPUEnableE && (lat > 6'd1);
        // E reaches M either as a plain op from IDLE or as the finishing op from BUSY
        capture = !clear && ((state_q == IDLE) ? !mc : (cnt_q == '0));
        StallE  = reset && !clear && ((state_q == IDLE) ? mc : (cnt_q != '0));
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            regw_q  <= 1'b0;
            fregw_q <= 1'b0;
            memw_q  <= 1'b0;
            rsrc_q  <= 1'b0;
            jmp_q   <= '0;
            fun3_q  <= '0;
            rd_q    <= '0;
        end else begin
            regw_q  <= capture && RegWriteE;
            fregw_q <= capture && FRegWriteE;
            memw_q  <= capture && MemWriteE;
            rsrc_q  <= capture && ResultSrcE;
            jmp_q   <= capture ? JmpE  : '0;
            fun3_q  <= capture ? Fun3E : '0;
            rd_q    <= capture ? RdE   : '0;
            case (state_q)
                IDLE: begin
                    if (!clear && mc) begin
                        state_q <= BUSY;
                        busy_q  <= 1'b1;
                        cnt_q   <= lat - 6'd2;
                    end
                end
                BUSY: begin
                    if (clear || cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                    end
                end
            endcase
        end
    end

`ifdef CTRL_EM_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (StallE) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign StallCnt = stall_cnt_q;
`endif

    assign RegWriteM  = regw_q;
    assign FRegWriteM = fregw_q;
    assign MemWriteM  = memw_q;
    assign ResultSrcM = rsrc_q;
    assign JmpM       = jmp_q;
    assign Fun3M      = fun3_q;
    assign RdM        = rd_q;
    assign FpuBusy    = busy_q;

endmodule
